// File: rtl/axi_write_responder_pkg.sv
// rtl/axi_write_responder_pkg.sv - shared states, response codes and burst encodings
package axi_write_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  // Only full-word FIXED/INCR bursts are served; WRAP and the reserved code are rejected.
  function automatic logic aw_unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// rtl/axi_wr_addr_gen.sv - word address stepping and beat counting for one write burst
module axi_wr_addr_gen
  import axi_write_responder_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [3:0]        load_len,
  input  logic [1:0]        load_burst,
  input  logic              advance,
  output logic [MEM_AW-1:0] addr,
  output logic              last_beat
);

  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        beat_q, beat_d;
  logic [3:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;

  always_comb begin
    addr_d  = addr_q;
    beat_d  = beat_q;
    len_d   = len_q;
    burst_d = burst_q;
    if (load) begin
      addr_d  = load_addr;
      beat_d  = 4'd0;
      len_d   = load_len;
      burst_d = load_burst;
    end else if (advance) begin
      beat_d = beat_q + 4'd1;
      // Natural overflow of the MEM_AW-bit register gives the modulo wrap.
      if (burst_q == BURST_INCR) begin
        addr_d = addr_q + MEM_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q  <= '0;
      beat_q  <= 4'd0;
      len_q   <= 4'd0;
      burst_q <= 2'b00;
    end else begin
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      burst_q <= burst_d;
    end
  end

  assign addr      = addr_q;
  assign last_beat = (beat_q == len_q);

endmodule

// File: rtl/axi_write_responder.sv
// rtl/axi_write_responder.sv - single-outstanding AXI write slave driving a word-addressed memory
module axi_write_responder
  import axi_write_responder_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [7:0]        AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [7:0]        BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] DATA = ST_DATA;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0] state_q, state_d;
  logic [7:0] bid_q, bid_d;
  logic       err_q, err_d;

  logic              aw_hs;
  logic              w_hs;
  logic              last_beat;
  logic [MEM_AW-1:0] cur_addr;

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[31:MEM_AW+2], AWADDR[1:0]};

  assign AWREADY = (state_q == IDLE);
  assign WREADY  = (state_q == DATA);
  assign BVALID  = (state_q == RESP);
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;

  axi_wr_addr_gen #(
    .MEM_AW(MEM_AW)
  ) u_addr_gen (
    .clk        (ACLK),
    .resetn     (ARESETn),
    .load       (aw_hs),
    .load_addr  (AWADDR[MEM_AW+1:2]),
    .load_len   (AWLEN),
    .load_burst (AWBURST),
    .advance    (w_hs),
    .addr       (cur_addr),
    .last_beat  (last_beat)
  );

  always_comb begin
    state_d = state_q;
    bid_d   = bid_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (AWVALID) begin
          bid_d   = AWID;
          err_d   = aw_unsupported(AWSIZE, AWBURST);
          state_d = DATA;
        end
      end
      DATA: begin
        // AWLEN alone ends the burst; a misplaced WLAST only poisons the response.
        if (WVALID) begin
          if (WLAST != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (BREADY) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      bid_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bid_q   <= bid_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = (w_hs && !err_q) ? WSTRB : 4'b0000;
  assign mem_addr  = cur_addr;
  assign mem_wdata = WDATA;
  assign BID       = bid_q;
  assign BRESP     = ((state_q == RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_write_responder.sv
// tb/tb_axi_write_responder.sv - directed and randomized transaction checks against a burst-level model
module tb_axi_write_responder;

  localparam int MEM_AW = 14;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [7:0]        AWID;
  logic [31:0]       AWADDR;
  logic [3:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [7:0]        BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  axi_write_responder #(.MEM_AW(MEM_AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Burst-level reference: what the current transaction should produce.
  logic [7:0] m_id;
  int         m_addr;
  int         m_len;
  int         m_beat;
  bit         m_incr;
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int pre);
    for (int i = 0; i < pre; i++) begin
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b1; WSTRB = 4'hF; WLAST = 1'b1; WDATA = $urandom;
      #1;
      check("idle_awready", AWREADY, 1);
      check("idle_wready", WREADY, 0);
      check("idle_mem_we", mem_we, 0);
      check("idle_bvalid", BVALID, 0);
    end
    @(negedge ACLK);
    WVALID = 1'($urandom_range(0, 1)); WSTRB = 4'hF;
    AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
    #1;
    check("aw_awready", AWREADY, 1);
    check("aw_mem_we", mem_we, 0);
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    m_id   = id;
    m_addr = int'(addr / 4) % (1 << MEM_AW);
    m_len  = int'(len);
    m_beat = 0;
    m_incr = (burst == 2'b01);
    m_err  = (size != 3'b010) || (burst > 2'b01);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(negedge ACLK);
      WVALID = 1'b0;
      #1;
      check("gap_wready", WREADY, 1);
      check("gap_mem_we", mem_we, 0);
      check("gap_bvalid", BVALID, 0);
    end
    @(negedge ACLK);
    WVALID = 1'b1; WDATA = data; WSTRB = strb; WLAST = last;
    #1;
    check("w_wready", WREADY, 1);
    check("w_awready", AWREADY, 0);
    check("w_mem_we", mem_we, m_err ? 4'h0 : strb);
    if (!m_err) begin
      check("w_mem_addr", mem_addr, m_addr);
      check("w_mem_wdata", mem_wdata, data);
    end
    @(posedge ACLK);
    #1;
    WVALID = 1'b0;
    if (last != (m_beat == m_len)) m_err = 1'b1;
    if (m_incr) m_addr = (m_addr + 1) % (1 << MEM_AW);
    m_beat++;
  endtask

  task automatic do_b(input int stall);
    for (int i = 0; i < stall; i++) begin
      @(negedge ACLK);
      BREADY = 1'b0; WVALID = 1'b1; WSTRB = 4'hF; WLAST = 1'b1;
      #1;
      check("stall_bvalid", BVALID, 1);
      check("stall_bid", BID, m_id);
      check("stall_bresp", BRESP, m_err ? 2'b10 : 2'b00);
      check("stall_awready", AWREADY, 0);
      check("stall_wready", WREADY, 0);
      check("stall_mem_we", mem_we, 0);
    end
    @(negedge ACLK);
    BREADY = 1'b1; WVALID = 1'b0;
    #1;
    check("b_bvalid", BVALID, 1);
    check("b_bid", BID, m_id);
    check("b_bresp", BRESP, m_err ? 2'b10 : 2'b00);
    @(posedge ACLK);
    #1;
    BREADY = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                         input int stall, input int max_gap);
    send_aw(id, addr, len, size, burst, int'($urandom_range(0, 1)));
    for (int b = 0; b <= int'(len); b++) begin
      send_w($urandom, 4'($urandom), (b == int'(len)) ^ (b == bad_beat), int'($urandom_range(0, max_gap)));
    end
    do_b(stall);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    check("rst_awready", AWREADY, 1);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_bid", BID, 0);
    check("rst_mem_we", mem_we, 0);
    ARESETn = 1'b1;

    // Single beat, then INCR burst with fixed strobes
    send_aw(8'h12, 32'h0000_0010, 4'd0, 3'b010, 2'b01, 0);
    send_w(32'hDEADBEEF, 4'hF, 1'b1, 0);
    do_b(0);
    send_aw(8'h34, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 0);
    for (int b = 0; b < 4; b++) send_w($urandom, 4'h3, b == 3, 0);
    do_b(0);

    // Address wrap at the top of the word space; FIXED burst holds address
    run_txn(8'h56, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01, -1, 0, 0);
    run_txn(8'h57, 32'h0000_0200, 4'd2, 3'b010, 2'b00, -1, 0, 1);

    // Errors: bad size, early WLAST, WRAP burst
    run_txn(8'h78, 32'h0000_0040, 4'd1, 3'b001, 2'b01, -1, 0, 0);
    run_txn(8'h79, 32'h0000_0080, 4'd1, 3'b010, 2'b01, 0, 0, 0);
    run_txn(8'h7A, 32'h0000_0080, 4'd1, 3'b010, 2'b10, -1, 0, 0);

    // B backpressure, then immediate next AW
    run_txn(8'h9A, 32'h0000_0300, 4'd0, 3'b010, 2'b01, -1, 5, 0);
    run_txn(8'h9B, 32'h0000_0304, 4'd0, 3'b010, 2'b01, -1, 0, 0);

    // Reset after 2 of 4 beats abandons the burst
    send_aw(8'hAB, 32'h0000_0400, 4'd3, 3'b010, 2'b01, 0);
    send_w($urandom, 4'hF, 1'b0, 0);
    send_w($urandom, 4'hF, 1'b0, 0);
    @(negedge ACLK);
    ARESETn = 1'b0; WVALID = 1'b0;
    @(posedge ACLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      if (i == 1) ARESETn = 1'b1;
      WVALID = 1'b1; WSTRB = 4'hF; WLAST = 1'b0;
      #1;
      check("mrst_awready", AWREADY, 1);
      check("mrst_wready", WREADY, 0);
      check("mrst_bvalid", BVALID, 0);
      check("mrst_mem_we", mem_we, 0);
    end
    WVALID = 1'b0;

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [2:0] sz;
      logic [1:0] bt;
      int bad;
      sz  = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b010;
      bt  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'($urandom_range(0, 1));
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_txn(8'($urandom), $urandom, 4'($urandom), sz, bt, bad,
              int'($urandom_range(0, 3)), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_write_responder.md
AXI_WRITE_RESPONDER -- requirements
Module: axi_write_responder

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 14, giving the memory word-address width.
REQ-002 The block SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port ARESETn, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have these AW-channel ports:
- AWID, input, 8 bits: write ID, bus-extended with master tag in the upper 4 bits.
- AWADDR, input, 32 bits: byte address.
- AWLEN, input, 4 bits: beats minus 1.
- AWSIZE, input, 3 bits: beat size.
- AWBURST, input, 2 bits: burst type.
- AWVALID, input, 1 bit.
- AWREADY, output, 1 bit.
REQ-005 The block SHALL have these W-channel ports:
- WDATA, input, 32 bits.
- WSTRB, input, 4 bits: byte strobes.
- WLAST, input, 1 bit.
- WVALID, input, 1 bit.
- WREADY, output, 1 bit.
REQ-006 The block SHALL have these B-channel ports:
- BID, output, 8 bits.
- BRESP, output, 2 bits.
- BVALID, output, 1 bit.
- BREADY, input, 1 bit.
REQ-007 The block SHALL have these memory-side ports:
- mem_we, output, 4 bits: per-byte write enable, active-high.
- mem_addr, output, MEM_AW bits: word address.
- mem_wdata, output, 32 bits.

Function
REQ-008 The FSM SHALL have three states, with AWREADY=1 only in IDLE, WREADY=1 only in DATA, and BVALID=1 only in RESP:
- IDLE (accept AW)
- DATA (accept W beats)
- RESP (present B)
REQ-009 An AW handshake in IDLE SHALL latch the following and enter DATA on the next edge:
- AWID into the BID register.
- AWADDR[MEM_AW+1:2] into the address register.
- AWLEN and AWBURST.
- Beat counter cleared to 0.
- Error flag set if AWSIZE != 3'b010 or AWBURST is neither FIXED (2'b00) nor INCR (2'b01).
REQ-010 Each W handshake in DATA SHALL drive the following combinationally in the same cycle; mem_we SHALL be 4'b0 in every other cycle:
- mem_we = WSTRB, but only when the error flag is clear.
- mem_addr = current address register.
- mem_wdata = WDATA.
REQ-011 After each W handshake, INCR SHALL add 1 to the address register, wrapping modulo 2^MEM_AW; FIXED SHALL hold the address.
REQ-012 The beat counter SHALL increment per W handshake; the beat where counter == latched AWLEN is the final beat, and the FSM SHALL enter RESP on the next edge.
REQ-013 The error flag SHALL be set if WLAST=1 on a non-final beat or WLAST=0 on the final beat. The burst length is always set by AWLEN, never by WLAST.
REQ-014 In RESP, BRESP SHALL be 2'b10 (SLVERR) if the error flag is set, else 2'b00 (OKAY). BID, BRESP and BVALID SHALL stay stable until BREADY.
REQ-015 A B handshake SHALL return the FSM to IDLE on the next edge and clear the error flag; AWREADY SHALL be 1 in the following cycle.
REQ-016 Latency SHALL be as follows:
- AW handshake at cycle T gives WREADY=1 from T+1.
- Final W handshake at cycle U gives BVALID=1 at U+1.
- Minimum single-beat transaction is 3 cycles, IDLE to IDLE.
REQ-017 Only one transaction SHALL be outstanding; AWVALID arriving while not in IDLE SHALL be held off by AWREADY=0.
REQ-018 WVALID in IDLE or RESP SHALL be ignored, with no memory write and no state change.

Reset
REQ-019 While ARESETn=0 at a rising edge, the block SHALL set:
- state to IDLE.
- BID, address register, beat counter, latched length/burst and error flag to 0.
REQ-020 Because the reset state is IDLE, the outputs during and after reset SHALL be AWREADY=1, WREADY=0, BVALID=0, BRESP=2'b00 and mem_we=4'b0.
REQ-021 Reset asserted mid-burst or in RESP SHALL abandon the transaction; remaining beats are not written and no B is issued.

Structure
REQ-022 A shared package SHALL hold:
- The state enum (IDLE/DATA/RESP).
- BRESP constants (OKAY=2'b00, SLVERR=2'b10).
- Burst encodings (FIXED=2'b00, INCR=2'b01, WRAP=2'b10).
- The supported-size constant 3'b010.
REQ-023 Address increment/wrap and the beat counter SHALL be one sub-module, axi_wr_addr_gen. The FSM and the B-channel registers SHALL stay in the top module.

Verification
REQ-024 Single beat: AWID=8'h12, AWADDR=32'h0000_0010, AWLEN=0, INCR, WDATA=32'hDEADBEEF, WSTRB=4'hF, WLAST=1 -> mem_we=4'hF at mem_addr=4; BVALID next cycle with BID=8'h12, BRESP=OKAY.
REQ-025 INCR burst: AWLEN=3, AWADDR=32'h100, WSTRB=4'h3 -> mem_addr 64,65,66,67, each with mem_we=4'h3; one B, OKAY.
REQ-026 Address wrap (MEM_AW=14): AWADDR=32'h0000_FFFC, AWLEN=1, INCR -> mem_addr 16383 then 0.
REQ-027 Errors, each checked on its own:
- AWSIZE=3'b001 -> no mem_we during the beats; BRESP=SLVERR.
- WLAST=1 on beat 0 of an AWLEN=1 burst -> both beats are still consumed; BRESP=SLVERR.
REQ-028 Backpressure: hold BREADY=0 for 5 cycles -> BVALID/BID/BRESP stable and AWREADY=0 throughout; next AW accepted the cycle after BREADY=1.
REQ-029 Reset mid-burst: ARESETn=0 after 2 of 4 beats -> next cycle AWREADY=1, WREADY=0, BVALID=0; no further mem_we.
